instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
- Parametrised instruction-fetch front end for the next-generation RISCuin core.
- Replaces the combinational program-memory read with a request/response memory port of variable latency.
- Buffers prefetched instructions in a DEPTH-entry queue and hands them to the decoder with a valid/ready handshake.
- Supports branch/jump redirect with flush, and raises a sticky pc_end when the last word of instruction space is consumed.

Parameters:
- INSTR_ADDR_WIDTH, 8, word-address width; instruction space is 2**INSTR_ADDR_WIDTH words.
- DEPTH, 4, queue entries; power of two, minimum 2.
- RESET_PC, 0, word address fetched first after reset.
- CW, $clog2(DEPTH+1), width of the level output (derived; not to be overridden).

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-low reset.
- mem_req, output, 1, fetch request; held until accepted.
- mem_addr, output, INSTR_ADDR_WIDTH, word address of the request.
- mem_valid, input, 1, response strobe; completes the request in the same cycle it is seen with mem_req=1.
- mem_rdata, input, 32, instruction word returned with mem_valid.
- out_valid, output, 1, head of queue holds a valid instruction.
- out_ready, input, 1, decoder accepts the head entry.
- out_instr, output, 32, head instruction.
- out_pc, output, INSTR_ADDR_WIDTH, word address of the head instruction.
- redirect, input, 1, flush the queue and restart fetch.
- redirect_pc, input, INSTR_ADDR_WIDTH, new fetch word address.
- level, output, CW, number of valid queue entries.
- pc_end, output, 1, sticky end-of-program flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - mem_req=0, mem_addr=RESET_PC, out_valid=0, level=0, pc_end=0.
  - fetch_pc=RESET_PC; internal flags busy, drop and fetch_done all cleared.
- Handshakes:
  - Pop occurs on a cycle with out_valid && out_ready.
  - A request completes on a cycle with mem_req && mem_valid.
  - Zero-wait memory is allowed; in that case requests may issue back-to-back, one per cycle.
- Issue rule: mem_req=1 when all of the following hold:
  - !pc_end and !fetch_done;
  - level + busy < DEPTH (in-flight slot is reserved, so a push never meets a full queue);
  - or a request is already pending (busy).
- Request stability: mem_addr and mem_req remain stable until completion. A request is never withdrawn, including on redirect or when the queue is full.
- On completion without drop:
  - Push {mem_rdata, mem_addr} at the tail.
  - fetch_pc <= mem_addr+1.
  - If mem_addr == all-ones, set fetch_done; fetch_pc does not wrap.
- Push and pop in the same cycle: level unchanged.
- Empty queue: out_valid=0; out_instr/out_pc are don't-care.
- Output timing: data becomes visible at the head the cycle after the push (registered queue, 1-cycle minimum latency from mem_valid to out_valid).
- Redirect (when !pc_end):
  - Next cycle: level=0, out_valid=0; a same-cycle pop is ignored; fetch_pc=redirect_pc; fetch_done cleared.
  - A same-cycle completion is discarded.
  - If a request is pending but incomplete, it stays asserted until mem_valid. Its data is discarded (drop=1), then fetching resumes at redirect_pc.
  - Back-to-back redirects: the last one wins.
- pc_end:
  - Set on the cycle after popping an entry with out_pc == all-ones.
  - Once set: remains set until reset, queue flushed, no further requests, redirect ignored.
  - A request pending at that moment completes and is dropped.
- level = pushes − pops, always ≤ DEPTH; wraps of internal pointers are modulo DEPTH.

Test Plan:
- Reset release, zero-wait memory (mem_valid=mem_req, mem_rdata=addr+0x100), out_ready=1:
  - mem_addr steps 0,1,2,… one per cycle.
  - out_valid rises one cycle after the first completion.
  - out_pc/out_instr = 0/0x100, 1/0x101, … with no gaps.
- DEPTH=4, out_ready=0:
  - Exactly 4 completions, then mem_req=0 and level=4.
  - Raising out_ready pops pcs 0–3 in order, and fetch resumes at 4.
- 3-cycle memory latency; redirect to 0x20 pulsed while the request for 0x05 is pending:
  - mem_addr stays 0x05 until mem_valid; that response is not pushed.
  - The next mem_addr is 0x20; the first out_pc after the redirect is 0x20.
- Redirect, pop and completion in the same cycle:
  - Next cycle level=0, out_valid=0, no entry duplicated.
  - The next request is to redirect_pc.
- INSTR_ADDR_WIDTH=5, run from 0:
  - The last request is 31; no request to 0 follows.
  - pc_end rises the cycle after pc 31 is popped.
  - A subsequent redirect to 3 leaves mem_req=0 and pc_end=1.
- rst driven low between edges during a pending request:
  - mem_req, out_valid, level and pc_end go to 0 immediately.
  - After release, the first mem_addr is RESET_PC.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: prefetching instruction front end with redirect flush and sticky end-of-program flag
module instr_fetch_queue #(
  parameter int INSTR_ADDR_WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [INSTR_ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int CW = $clog2(DEPTH+1)
)(
  input  logic                        clk,
  input  logic                        rst,
  output logic                        mem_req,
  output logic [INSTR_ADDR_WIDTH-1:0] mem_addr,
  input  logic                        mem_valid,
  input  logic [31:0]                 mem_rdata,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 out_instr,
  output logic [INSTR_ADDR_WIDTH-1:0] out_pc,
  input  logic                        redirect,
  input  logic [INSTR_ADDR_WIDTH-1:0] redirect_pc,
  output logic [CW-1:0]               level,
  output logic                        pc_end
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [INSTR_ADDR_WIDTH-1:0] LAST = '1;
  logic [31:0] instr_q [DEPTH];
  logic [INSTR_ADDR_WIDTH-1:0] pc_q [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [INSTR_ADDR_WIDTH-1:0] fetch_pc, req_addr;
  logic run, busy, drop, fetch_done, end_q;
  logic complete, push, pop, flush, set_end;
  assign mem_req = busy | (run & ~end_q & ~fetch_done & (count < FULL));
  assign mem_addr = busy ? req_addr : fetch_pc;
  assign out_valid = count != '0;
  assign out_instr = instr_q[rd_ptr];
  assign out_pc = pc_q[rd_ptr];
  assign level = count;
  assign pc_end = end_q;
  assign complete = mem_req & mem_valid;
  assign pop = out_valid & out_ready;
  assign set_end = pop & (out_pc == LAST);
  assign flush = (redirect & ~end_q) | set_end;
  assign push = complete & ~drop & ~flush;
  // control state: outstanding request tracking, queue pointers, fetch address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run <= 1'b0;
      busy <= 1'b0;
      drop <= 1'b0;
      fetch_done <= 1'b0;
      end_q <= 1'b0;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      run <= 1'b1;
      busy <= mem_req & ~mem_valid;
      drop <= mem_req & ~mem_valid & (drop | flush);
      req_addr <= mem_addr;
      end_q <= end_q | set_end;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count <= '0;
      end else begin
        rd_ptr <= rd_ptr + PW'(pop);
        wr_ptr <= wr_ptr + PW'(push);
        count <= count + CW'(push) - CW'(pop);
      end
      if (redirect & ~end_q) begin
        fetch_pc <= redirect_pc;
        fetch_done <= 1'b0;
      end else if (push) begin
        fetch_pc <= (mem_addr == LAST) ? mem_addr : mem_addr + 1'b1;
        fetch_done <= mem_addr == LAST;
      end
    end
  end
  // queue storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= mem_rdata;
      pc_q[wr_ptr] <= mem_addr;
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;
  logic clk = 1'b0, rst = 1'b0, mem_valid = 1'b0, out_ready = 1'b0, redirect = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [7:0] redirect_pc = '0;
  logic mem_req, out_valid, pc_end;
  logic [7:0] mem_addr, out_pc;
  logic [31:0] out_instr;
  logic [2:0] level;
  int n_assert = 0, n_fail = 0, lat = 0, wcnt = 0;

  instr_fetch_queue dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .level(level), .pc_end(pc_end)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock step; at the falling edge the memory model answers a request after lat waiting cycles
  task automatic cyc();
    @(negedge clk);
    if (mem_req) begin
      if (wcnt >= lat) begin
        mem_valid = 1'b1;
        mem_rdata = 32'h100 + 32'(mem_addr);
        wcnt = 0;
      end else begin
        mem_valid = 1'b0;
        wcnt++;
      end
    end else begin
      mem_valid = 1'b0;
      wcnt = 0;
    end
  endtask

  task automatic wait_req();
    int k = 0;
    while (!mem_req && k < 5) begin
      cyc();
      k++;
    end
    chk("req_after_reset", 32'(mem_req), 32'd1);
  endtask

  initial begin
    repeat (2) cyc();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_pc_end", 32'(pc_end), 32'd0);
    out_ready = 1'b1;
    rst = 1'b1;
    wait_req();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cyc();
      chk("t1_addr", 32'(mem_addr), 32'(i));
      chk("t1_valid", 32'(out_valid), 32'(i > 0));
      if (i > 0) begin
        chk("t1_pc", 32'(out_pc), 32'(i - 1));
        chk("t1_instr", out_instr, 32'h100 + 32'(i - 1));
        chk("t1_level", 32'(level), 32'd1);
      end
    end
    out_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 8'h00;
    for (int j = 0; j < 4; j++) begin
      cyc();
      redirect = 1'b0;
      chk("t2_req", 32'(mem_req), 32'd1);
      chk("t2_addr", 32'(mem_addr), 32'(j));
      chk("t2_level", 32'(level), 32'(j));
    end
    for (int j = 0; j < 3; j++) begin
      cyc();
      chk("t2_full_req", 32'(mem_req), 32'd0);
      chk("t2_full_level", 32'(level), 32'd4);
      chk("t2_head_pc", 32'(out_pc), 32'd0);
    end
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      cyc();
      chk("t2_pop_pc", 32'(out_pc), 32'(k));
      chk("t2_resume_addr", 32'(mem_addr), 32'(k + 3));
      chk("t2_pop_level", 32'(level), 32'd3);
    end
    redirect = 1'b1;
    redirect_pc = 8'h40;
    cyc();
    redirect = 1'b0;
    chk("t3_level", 32'(level), 32'd0);
    chk("t3_valid", 32'(out_valid), 32'd0);
    chk("t3_addr", 32'(mem_addr), 32'h40);
    chk("t3_req", 32'(mem_req), 32'd1);
    cyc();
    chk("t3_valid2", 32'(out_valid), 32'd1);
    chk("t3_pc", 32'(out_pc), 32'h40);
    chk("t3_instr", out_instr, 32'h140);
    chk("t3_level2", 32'(level), 32'd1);
    chk("t3_addr2", 32'(mem_addr), 32'h41);
    lat = 2;
    redirect = 1'b1;
    redirect_pc = 8'h05;
    cyc();
    chk("t4_addr_a", 32'(mem_addr), 32'h05);
    chk("t4_level_a", 32'(level), 32'd0);
    redirect_pc = 8'h20;
    cyc();
    redirect = 1'b0;
    chk("t4_addr_b", 32'(mem_addr), 32'h05);
    chk("t4_req_b", 32'(mem_req), 32'd1);
    cyc();
    chk("t4_addr_c", 32'(mem_addr), 32'h05);
    for (int j = 0; j < 3; j++) begin
      cyc();
      chk("t4_addr_new", 32'(mem_addr), 32'h20);
      chk("t4_no_push", 32'(out_valid), 32'd0);
    end
    cyc();
    chk("t4_valid", 32'(out_valid), 32'd1);
    chk("t4_pc", 32'(out_pc), 32'h20);
    chk("t4_instr", out_instr, 32'h120);
    chk("t4_addr_next", 32'(mem_addr), 32'h21);
    lat = 0;
    redirect = 1'b1;
    redirect_pc = 8'hFC;
    cyc();
    redirect = 1'b0;
    chk("t5_held_addr", 32'(mem_addr), 32'h21);
    chk("t5_held_level", 32'(level), 32'd0);
    cyc();
    chk("t5_addr_fc", 32'(mem_addr), 32'hFC);
    chk("t5_empty", 32'(out_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t5_pc", 32'(out_pc), 32'hFC + 32'(k));
      chk("t5_addr", 32'(mem_addr), 32'hFD + 32'(k));
    end
    cyc();
    chk("t5_last_req", 32'(mem_req), 32'd0);
    chk("t5_last_pc", 32'(out_pc), 32'hFF);
    chk("t5_last_valid", 32'(out_valid), 32'd1);
    chk("t5_end_low", 32'(pc_end), 32'd0);
    cyc();
    chk("t5_end_high", 32'(pc_end), 32'd1);
    chk("t5_end_valid", 32'(out_valid), 32'd0);
    chk("t5_end_level", 32'(level), 32'd0);
    chk("t5_end_req", 32'(mem_req), 32'd0);
    redirect = 1'b1;
    redirect_pc = 8'h03;
    cyc();
    redirect = 1'b0;
    chk("t5_redir_req", 32'(mem_req), 32'd0);
    chk("t5_redir_end", 32'(pc_end), 32'd1);
    cyc();
    chk("t5_redir_req2", 32'(mem_req), 32'd0);
    #2;
    rst = 1'b0;
    mem_valid = 1'b0;
    wcnt = 0;
    #1;
    chk("t6_end_clr", 32'(pc_end), 32'd0);
    chk("t6_req_clr", 32'(mem_req), 32'd0);
    cyc();
    rst = 1'b1;
    out_ready = 1'b0;
    wait_req();
    chk("t6_first_addr", 32'(mem_addr), 32'd0);
    cyc();
    lat = 3;
    chk("t6_addr1", 32'(mem_addr), 32'd1);
    chk("t6_level1", 32'(level), 32'd1);
    cyc();
    chk("t6_addr2", 32'(mem_addr), 32'd2);
    chk("t6_level2", 32'(level), 32'd2);
    chk("t6_pending", 32'(mem_valid), 32'd0);
    #2;
    rst = 1'b0;
    mem_valid = 1'b0;
    wcnt = 0;
    #1;
    chk("t6_async_req", 32'(mem_req), 32'd0);
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk("t6_async_level", 32'(level), 32'd0);
    chk("t6_async_end", 32'(pc_end), 32'd0);
    cyc();
    rst = 1'b1;
    wait_req();
    chk("t6_restart_addr", 32'(mem_addr), 32'd0);
    chk("t6_restart_level", 32'(level), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
